spi_test: RTL and testbench

// - SPI display exerciser: drives an SSD1306-style OLED over write-only 4-wire SPI (cs/scl/sda/dc).
// - After reset it sends a fixed init command sequence, then paints a full frame.
// - Each btn[3:0] rising edge selects one of four test patterns and triggers a repaint.
// - Board-level demo/bring-up block sitting between the push-buttons and the display header.

---
 rtl/spi_test_if.sv | 10 +
 rtl/spi_test.sv | 213 +++++++++++++++++++++
 tb/tb_spi_test.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/spi_test_if.sv
// Write-only 4-wire SPI link to an SSD1306-style display: chip select, clock, data, data/command.
interface spi_test_if;
  logic cs;
  logic scl;
  logic sda;
  logic dc;

  modport master (output cs, scl, sda, dc);
  modport slave  (input  cs, scl, sda, dc);
endinterface

// File: rtl/spi_test.sv
// SPI display exerciser: sends init commands, paints a frame, then repaints on button requests.
// One byte every 16*CLK_DIV+2 cycles; button requests queue in a single pending slot, never abort a frame.
module spi_test #(
  parameter int CLK_DIV    = 2,
  parameter int FILL_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  btn,
  spi_test_if.master  spi
);

  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam int IW = $clog2(FILL_BYTES);

  typedef enum logic [1:0] {S_INIT, S_ADDR, S_FILL, S_IDLE} seq_t;
  typedef enum logic [1:0] {P_OFF, P_SHIFT, P_GAP} ph_t;

  seq_t          seq, n_seq;
  ph_t           ph, n_ph;
  logic [DW-1:0] div, n_div;
  logic [2:0]    bit_cnt, n_bit;
  logic          sclh, n_sclh;
  logic [3:0]    cmd, n_cmd;
  logic [IW-1:0] idx, n_idx;
  logic [1:0]    pat, n_pat;
  logic          pend_vld, n_pend_vld;
  logic [1:0]    pend_pat, n_pend_pat;
  logic [3:0]    bsync1, bsync2, bprev;
  logic [3:0]    rise;
  logic          req_vld;
  logic [1:0]    req_pat;
  logic [7:0]    tx_byte;
  logic [7:0]    idx8;

  function automatic logic [7:0] init_cmd(input logic [3:0] i);
    case (i)
      4'd0:    return 8'hAE;
      4'd1:    return 8'hA8;
      4'd2:    return 8'h3F;
      4'd3:    return 8'hD3;
      4'd4:    return 8'h00;
      4'd5:    return 8'h40;
      4'd6:    return 8'hA1;
      4'd7:    return 8'hC8;
      4'd8:    return 8'h8D;
      4'd9:    return 8'h14;
      4'd10:   return 8'hAF;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] addr_cmd(input logic [3:0] i);
    case (i)
      4'd0:    return 8'h21;
      4'd1:    return 8'h00;
      4'd2:    return 8'h7F;
      4'd3:    return 8'h22;
      4'd4:    return 8'h00;
      4'd5:    return 8'h07;
      default: return 8'h00;
    endcase
  endfunction

  // Rising edge of the synchronised buttons; lowest index wins on a tie.
  always_comb begin
    rise    = bsync2 & ~bprev;
    req_vld = |rise;
    req_pat = 2'd0;
    if      (rise[0]) req_pat = 2'd0;
    else if (rise[1]) req_pat = 2'd1;
    else if (rise[2]) req_pat = 2'd2;
    else if (rise[3]) req_pat = 2'd3;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq      <= S_INIT;
      ph       <= P_OFF;
      div      <= '0;
      bit_cnt  <= '0;
      sclh     <= 1'b0;
      cmd      <= '0;
      idx      <= '0;
      pat      <= 2'd0;
      pend_vld <= 1'b0;
      pend_pat <= 2'd0;
      bsync1   <= '0;
      bsync2   <= '0;
      bprev    <= '0;
    end else begin
      seq      <= n_seq;
      ph       <= n_ph;
      div      <= n_div;
      bit_cnt  <= n_bit;
      sclh     <= n_sclh;
      cmd      <= n_cmd;
      idx      <= n_idx;
      pat      <= n_pat;
      pend_vld <= n_pend_vld;
      pend_pat <= n_pend_pat;
      bsync1   <= btn;
      bsync2   <= bsync1;
      bprev    <= bsync2;
    end
  end

  always_comb begin
    n_seq      = seq;
    n_ph       = ph;
    n_div      = div;
    n_bit      = bit_cnt;
    n_sclh     = sclh;
    n_cmd      = cmd;
    n_idx      = idx;
    n_pat      = pat;
    n_pend_vld = pend_vld;
    n_pend_pat = pend_pat;
    case (ph)
      P_OFF: begin
        if (seq != S_IDLE || pend_vld) begin
          n_ph   = P_SHIFT;
          n_div  = '0;
          n_bit  = '0;
          n_sclh = 1'b0;
        end
        // A frame only starts here, so the pattern can never change mid-frame.
        if (seq == S_IDLE && pend_vld) begin
          n_seq      = S_ADDR;
          n_cmd      = '0;
          n_idx      = '0;
          n_pat      = pend_pat;
          n_pend_vld = 1'b0;
        end
      end
      P_SHIFT: begin
        if (div == DW'(CLK_DIV - 1)) begin
          n_div = '0;
          if (sclh) begin
            n_sclh = 1'b0;
            if (bit_cnt == 3'd7) n_ph  = P_GAP;
            else                 n_bit = bit_cnt + 3'd1;
          end else begin
            n_sclh = 1'b1;
          end
        end else begin
          n_div = div + DW'(1);
        end
      end
      P_GAP: begin
        if (div == DW'(1)) begin
          n_div  = '0;
          n_bit  = '0;
          n_sclh = 1'b0;
          n_ph   = P_SHIFT;
          case (seq)
            S_INIT: begin
              if (cmd == 4'd10) begin
                n_seq = S_ADDR;
                n_cmd = '0;
                n_idx = '0;
              end else n_cmd = cmd + 4'd1;
            end
            S_ADDR: begin
              if (cmd == 4'd5) begin
                n_seq = S_FILL;
                n_idx = '0;
              end else n_cmd = cmd + 4'd1;
            end
            S_FILL: begin
              if (idx == IW'(FILL_BYTES - 1)) begin
                n_seq = S_IDLE;
                n_ph  = P_OFF;
              end else n_idx = idx + IW'(1);
            end
            default: n_ph = P_OFF;
          endcase
        end else begin
          n_div = div + DW'(1);
        end
      end
      default: n_ph = P_OFF;
    endcase
    if (req_vld) begin
      n_pend_vld = 1'b1;
      n_pend_pat = req_pat;
    end
  end

  always_comb begin
    idx8    = 8'(idx);
    tx_byte = 8'h00;
    case (seq)
      S_INIT: tx_byte = init_cmd(cmd);
      S_ADDR: tx_byte = addr_cmd(cmd);
      S_FILL: begin
        case (pat)
          2'd0:    tx_byte = 8'h00;
          2'd1:    tx_byte = 8'hFF;
          2'd2:    tx_byte = idx[0] ? 8'h55 : 8'hAA;
          default: tx_byte = idx8;
        endcase
      end
      default: tx_byte = 8'h00;
    endcase
    // bit_cnt only advances on the falling scl edge, so sda is stable while scl is high.
    spi.cs  = (ph != P_SHIFT);
    spi.scl = (ph == P_SHIFT) && sclh;
    spi.sda = (ph == P_SHIFT) && tx_byte[3'd7 - bit_cnt];
    spi.dc  = (seq == S_FILL);
  end

endmodule

// File: tb/tb_spi_test.sv
// Bench for spi_test: decodes the SPI stream and checks every byte against a scoreboard of expected frames.
module tb_spi_test;
  localparam int CLK_DIV = 2;
  localparam int FILL    = 264;
  localparam int PERIOD  = 16 * CLK_DIV + 2;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] btn   = 4'b0000;

  spi_test_if spi ();

  spi_test #(.CLK_DIV(CLK_DIV), .FILL_BYTES(FILL)) dut (
    .clk   (clk),
    .reset (reset),
    .btn   (btn),
    .spi   (spi)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;
  int cyc     = 0;
  // Entry: {first byte of a burst (spacing unchecked), dc, byte}
  logic [9:0] q[$];

  logic [7:0] init_tab[11] = '{8'hAE, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
                               8'hA1, 8'hC8, 8'h8D, 8'h14, 8'hAF};
  logic [7:0] addr_tab[6]  = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_data(input int pat, input int i);
    case (pat)
      0:       return 8'h00;
      1:       return 8'hFF;
      2:       return (i % 2 == 0) ? 8'hAA : 8'h55;
      default: return 8'(i % 256);
    endcase
  endfunction

  task automatic push_init();
    for (int i = 0; i < 11; i++) q.push_back({(i == 0), 1'b0, init_tab[i]});
  endtask

  task automatic push_frame(input int pat, input bit first);
    for (int i = 0; i < 6; i++) q.push_back({(first && i == 0), 1'b0, addr_tab[i]});
    for (int i = 0; i < FILL; i++) q.push_back({1'b0, 1'b1, exp_data(pat, i)});
  endtask

  task automatic pulse(input logic [3:0] b);
    @(negedge clk);
    btn = b;
    @(negedge clk);
    btn = 4'b0000;
  endtask

  task automatic wait_q_below(input int n, input int budget, input string tag);
    int k = 0;
    while (q.size() >= n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(q.size() < n), 32'd1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // SPI decoder: samples on the falling clk edge, away from DUT updates.
  logic       prev_cs = 1'b1, prev_scl = 1'b0, prev_sda = 1'b0, byte_dc = 1'b0;
  logic [7:0] shreg = 8'h00;
  logic [9:0] e;
  int         nbits = 0, cur_start = 0, last_start = 0;

  always @(negedge clk) begin
    if (!reset) begin
      prev_cs  = 1'b1;
      prev_scl = 1'b0;
      prev_sda = 1'b0;
      nbits    = 0;
    end else begin
      if (spi.cs) check("scl_idle_while_cs_high", 32'(spi.scl), 32'd0);
      if (prev_cs && !spi.cs) begin
        cur_start = cyc;
        nbits     = 0;
      end
      if (!prev_cs && spi.cs) check("scl_rises_per_byte", nbits, 32'd8);
      if (!spi.cs && spi.scl && prev_scl) check("sda_stable_scl_high", 32'(spi.sda), 32'(prev_sda));
      if (!spi.cs && spi.scl && !prev_scl) begin
        if (nbits == 0) byte_dc = spi.dc;
        else check("dc_stable_in_byte", 32'(spi.dc), 32'(byte_dc));
        shreg = {shreg[6:0], spi.sda};
        nbits++;
        if (nbits == 8) begin
          check("byte_expected", 32'(q.size() > 0), 32'd1);
          if (q.size() > 0) begin
            e = q.pop_front();
            check("spi_byte_dc", 32'({byte_dc, shreg}), 32'(e[8:0]));
            if (!e[9]) check("byte_spacing", cur_start - last_start, PERIOD);
            last_start = cur_start;
          end
        end
      end
      prev_cs  = spi.cs;
      prev_scl = spi.scl;
      prev_sda = spi.sda;
    end
  end

  initial begin
    int k;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_cs",  32'(spi.cs),  32'd1);
    check("reset_scl", 32'(spi.scl), 32'd0);
    check("reset_sda", 32'(spi.sda), 32'd0);
    check("reset_dc",  32'(spi.dc),  32'd0);

    push_init();
    push_frame(0, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("first_launch_cs", 32'(spi.cs), 32'd0);
    wait_q_below(1, 20000, "frame0_drained");
    repeat (20) @(negedge clk);
    check("idle_cs",  32'(spi.cs),  32'd1);
    check("idle_sda", 32'(spi.sda), 32'd0);

    push_frame(1, 1'b1);
    pulse(4'b0010);
    wait_q_below(1, 20000, "frame_ff_drained");

    push_frame(3, 1'b1);
    pulse(4'b1000);
    wait_q_below(1, 20000, "frame_count_drained");

    // Requests during a frame: the later one (btn2) replaces the earlier one (btn3).
    push_frame(1, 1'b1);
    pulse(4'b0010);
    wait_q_below(200, 20000, "frame_ff2_running");
    pulse(4'b1000);
    repeat (10) @(negedge clk);
    pulse(4'b0100);
    push_frame(2, 1'b1);
    wait_q_below(100, 20000, "frame_aa55_running");
    pulse(4'b1001);
    push_frame(0, 1'b1);
    wait_q_below(150, 20000, "frame_zero_running");

    k = 0;
    while (spi.scl !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("scl_high_before_reset", 32'(spi.scl), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("midreset_cs",  32'(spi.cs),  32'd1);
    check("midreset_scl", 32'(spi.scl), 32'd0);
    check("midreset_sda", 32'(spi.sda), 32'd0);
    q.delete();
    repeat (3) @(negedge clk);
    push_init();
    reset = 1'b1;
    wait_q_below(1, 2000, "restart_init_drained");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
